// File: rtl/hazard_stall_unit.sv
// Load-use / branch / data-memory-wait hazard controller for the 5-stage core.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_stall_unit #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        id_ex_mem_read,
    input  logic [4:0]  id_ex_rd,
    input  logic        ex_branch_taken,
    input  logic        ex_mem_mem_access,
    input  logic        dmem_ready,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        pipe_hold,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events,
    output logic [31:0] freeze_cycles
);
    localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(MEM_TIMEOUT);

    typedef enum logic [1:0] {S_RUN, S_MEM_WAIT, S_ERROR} state_t;

    state_t        r_state, w_state_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic          r_mem_timeout;
    logic          w_lu, w_fz, w_br_act, w_lu_act;
    logic          w_pc_write, w_if_id_write, w_if_id_flush, w_id_ex_bubble, w_pipe_hold;

    assign w_lu = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                  ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
                   (id_uses_rs2 && (id_rs2 == id_ex_rd)));

    always_comb begin
        w_fz        = 1'b0;
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        case (r_state)
            S_RUN: begin
                w_fz        = ex_mem_mem_access && !dmem_ready;
                w_timer_nxt = '0;
                if (w_fz) begin
                    w_state_nxt = S_MEM_WAIT;
                    w_timer_nxt = TW'(1);
                end
            end
            S_MEM_WAIT: begin
                w_fz = !dmem_ready;
                if (dmem_ready) begin
                    w_state_nxt = S_RUN;
                    w_timer_nxt = '0;
                end else if (r_timer == TIMER_MAX) begin
                    w_state_nxt = S_ERROR;
                end else begin
                    w_timer_nxt = r_timer + TW'(1);
                end
            end
            S_ERROR: begin
                w_fz = 1'b1;
            end
            default: begin
                w_state_nxt = S_RUN;
                w_timer_nxt = '0;
            end
        endcase
    end

    // Priority: freeze, then branch squash, then load-use stall.
    assign w_br_act = !w_fz && ex_branch_taken;
    assign w_lu_act = !w_fz && !ex_branch_taken && w_lu;

    always_comb begin
        w_pc_write     = 1'b1;
        w_if_id_write  = 1'b1;
        w_if_id_flush  = 1'b0;
        w_id_ex_bubble = 1'b0;
        w_pipe_hold    = 1'b0;
        if (w_fz) begin
            w_pc_write    = 1'b0;
            w_if_id_write = 1'b0;
            w_pipe_hold   = 1'b1;
        end else if (w_br_act) begin
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
        end else if (w_lu_act) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_bubble = 1'b1;
        end
    end

    // Reset forces the pipeline to free-run regardless of the hazard inputs.
    assign pc_write     = w_pc_write    || !rst_n;
    assign if_id_write  = w_if_id_write || !rst_n;
    assign if_id_flush  = w_if_id_flush  && rst_n;
    assign id_ex_bubble = w_id_ex_bubble && rst_n;
    assign pipe_hold    = w_pipe_hold    && rst_n;
    assign mem_timeout  = r_mem_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RUN;
            r_timer       <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            r_mem_timeout <= r_mem_timeout || (w_state_nxt == S_ERROR);
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cycles, r_flush_events, r_freeze_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles  <= '0;
            r_flush_events  <= '0;
            r_freeze_cycles <= '0;
        end else begin
            if (w_lu_act && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_br_act && (r_flush_events != '1))
                r_flush_events <= r_flush_events + 32'd1;
            if (w_fz && (r_freeze_cycles != '1))
                r_freeze_cycles <= r_freeze_cycles + 32'd1;
        end
    end

    assign stall_cycles  = r_stall_cycles;
    assign flush_events  = r_flush_events;
    assign freeze_cycles = r_freeze_cycles;
`else
    assign stall_cycles  = '0;
    assign flush_events  = '0;
    assign freeze_cycles = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: driver pushes model expectations, monitor compares.
module tb_hazard_stall_unit;
    localparam int unsigned T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_ex_rd = '0;
    logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, id_ex_mem_read = 1'b0;
    logic        ex_branch_taken = 1'b0, ex_mem_mem_access = 1'b0, dmem_ready = 1'b0;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_timeout;
    logic [31:0] stall_cycles, flush_events, freeze_cycles;

    hazard_stall_unit #(.MEM_TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .ex_branch_taken(ex_branch_taken), .ex_mem_mem_access(ex_mem_mem_access),
        .dmem_ready(dmem_ready),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .pipe_hold(pipe_hold), .mem_timeout(mem_timeout),
        .stall_cycles(stall_cycles), .flush_events(flush_events), .freeze_cycles(freeze_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pc, ifw, fl, bub, hold, to;
        logic [31:0] sc, fe, fc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    // Reference model: count consecutive frozen cycles; error once they exceed the limit.
    int          m_streak = 0;
    bit          m_err = 0;
    longint      m_sc = 0, m_fe = 0, m_fc = 0;

    function automatic logic [31:0] sat(input longint v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic step(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
                        input logic br, input logic acc, input logic rdy);
        exp_t e;
        bit lu, fz;
        @(posedge clk);
        #1;
        rst_n = rst; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_ex_mem_read = mr; id_ex_rd = rd; ex_branch_taken = br;
        ex_mem_mem_access = acc; dmem_ready = rdy;
        if (!rst) begin
            m_streak = 0; m_err = 0; m_sc = 0; m_fe = 0; m_fc = 0;
            e = '{pc: 1, ifw: 1, fl: 0, bub: 0, hold: 0, to: 0, sc: 0, fe: 0, fc: 0};
            q.push_back(e);
            return;
        end
        lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        fz = m_err || ((m_streak > 0) ? !rdy : (acc && !rdy));
        e.to = m_err;
`ifdef HAZARD_PERF_EN
        e.sc = sat(m_sc); e.fe = sat(m_fe); e.fc = sat(m_fc);
`else
        e.sc = 0; e.fe = 0; e.fc = 0;
`endif
        if (fz)      begin e.pc = 0; e.ifw = 0; e.fl = 0; e.bub = 0; e.hold = 1; m_fc++; end
        else if (br) begin e.pc = 1; e.ifw = 1; e.fl = 1; e.bub = 1; e.hold = 0; m_fe++; end
        else if (lu) begin e.pc = 0; e.ifw = 0; e.fl = 0; e.bub = 1; e.hold = 0; m_sc++; end
        else         begin e.pc = 1; e.ifw = 1; e.fl = 0; e.bub = 0; e.hold = 0; end
        q.push_back(e);
        if (fz) begin
            m_streak++;
            if (m_streak == int'(T) + 1) m_err = 1;
        end else begin
            m_streak = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc_write",      32'(pc_write),     32'(e.pc));
            chk("if_id_write",   32'(if_id_write),  32'(e.ifw));
            chk("if_id_flush",   32'(if_id_flush),  32'(e.fl));
            chk("id_ex_bubble",  32'(id_ex_bubble), 32'(e.bub));
            chk("pipe_hold",     32'(pipe_hold),    32'(e.hold));
            chk("mem_timeout",   32'(mem_timeout),  32'(e.to));
            chk("stall_cycles",  stall_cycles,  e.sc);
            chk("flush_events",  flush_events,  e.fe);
            chk("freeze_cycles", freeze_cycles, e.fc);
        end
    end

    initial begin
        int n;
        // Reset with arbitrary hazard inputs
        step(0, 5, 5, 1, 1, 1, 5, 1, 1, 0);
        step(0, 3, 7, 1, 0, 1, 3, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Load-use, then rd=0 and uses=0 variants
        step(1, 5, 0, 1, 0, 1, 5, 0, 0, 1);
        step(1, 0, 0, 1, 0, 1, 0, 0, 0, 1);
        step(1, 5, 0, 0, 0, 1, 5, 0, 0, 1);
        step(1, 0, 9, 0, 1, 1, 9, 0, 0, 1);
        // Branch with load-use
        step(1, 5, 0, 1, 0, 1, 5, 1, 0, 1);
        // 3-cycle memory wait, then ready
        repeat (3) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        // Single-cycle access: no freeze
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        // Branch held through a 2-cycle freeze
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        // Watchdog: 5 frozen cycles reach ERROR, ready does not release it
        repeat (5) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0);
        end
        n = 0;
        while (q.size() > 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "timeout");
    end
endmodule
